// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : FETCH/DECODE/EXECUTE/MEM/WB sequencer for the multi-cycle RV32I
//            core. It drives the shared memory port through a ready handshake.
//            A bus-timeout watchdog is included, and faults go to a sticky
//            TRAP state.
// Options  : MULTICYCLE_MULDIV_EN adds the MULDIV state for R-type
//            instructions with funct7[0]=1.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
   parameter int OP_EFF_WIDTH = 5,
   parameter int FUNCT3_WIDTH = 3,
   parameter int I_TYPE       = 0,
   parameter int S_TYPE       = 1,
   parameter int B_TYPE       = 2,
   parameter int J_TYPE       = 3,
   parameter int U_TYPE       = 4,
   parameter int MEM_TIMEOUT  = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [OP_EFF_WIDTH-1:0] opcode_eff,
   input  logic [FUNCT3_WIDTH-1:0] funct3,
   input  logic                    funct7_b0,
   input  logic                    BrEq,
   input  logic                    BrLT,
   input  logic                    mem_ready,
   input  logic                    md_done,
   output logic                    mem_req,
   output logic                    MemRW,
   output logic                    ir_we,
   output logic                    pc_we,
   output logic                    PCSel,
   output logic [2:0]              ImmSel,
   output logic                    RegWEn,
   output logic                    BrUn,
   output logic                    ASel,
   output logic                    BSel,
   output logic [1:0]              WBSel,
   output logic                    arithmetic,
   output logic                    i_type,
   output logic                    md_start,
   output logic                    md_sel,
   output logic                    trap,
   output logic [1:0]              trap_cause,
   output logic [2:0]              state
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_MULDIV  = 3'd5,
      S_TRAP    = 3'd6
   } state_t;

   localparam logic [OP_EFF_WIDTH-1:0] c_op_r      = OP_EFF_WIDTH'(5'b01100);
   localparam logic [OP_EFF_WIDTH-1:0] c_op_i      = OP_EFF_WIDTH'(5'b00100);
   localparam logic [OP_EFF_WIDTH-1:0] c_op_load   = OP_EFF_WIDTH'(5'b00000);
   localparam logic [OP_EFF_WIDTH-1:0] c_op_store  = OP_EFF_WIDTH'(5'b01000);
   localparam logic [OP_EFF_WIDTH-1:0] c_op_branch = OP_EFF_WIDTH'(5'b11000);
   localparam logic [OP_EFF_WIDTH-1:0] c_op_jal    = OP_EFF_WIDTH'(5'b11011);
   localparam logic [OP_EFF_WIDTH-1:0] c_op_jalr   = OP_EFF_WIDTH'(5'b11001);
   localparam logic [OP_EFF_WIDTH-1:0] c_op_auipc  = OP_EFF_WIDTH'(5'b00101);
   localparam logic [OP_EFF_WIDTH-1:0] c_op_lui    = OP_EFF_WIDTH'(5'b01101);

   // A zero timeout disables the watchdog; keep the counter at least 1 bit wide
   localparam int                c_wd_w     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [c_wd_w-1:0] c_wd_limit = c_wd_w'(MEM_TIMEOUT);
   localparam bit                c_wd_en    = (MEM_TIMEOUT != 0);

   state_t              r_state;
   logic                r_run;
   logic [c_wd_w-1:0]   r_wd_cnt;
   logic [1:0]          r_trap_cause;

   state_t              w_next_state;
   logic [c_wd_w-1:0]   w_next_cnt;
   logic [1:0]          w_next_cause;
   logic                w_wd_hit;

   logic                w_legal, w_r_legal, w_is_md;
   logic                w_is_load, w_is_store, w_is_branch, w_br_taken;
   logic [2:0]          w_imm_sel;
   logic [1:0]          w_wb_sel;
   logic                w_br_un, w_a_sel, w_b_sel, w_arith, w_itype, w_pc_sel;
   logic                w_in_fetch, w_in_exec, w_in_mem, w_in_wb, w_in_muldiv;
   logic                w_decoded;

`ifdef MULTICYCLE_MULDIV_EN
   assign w_r_legal = 1'b1;
   assign w_is_md   = (opcode_eff == c_op_r) && funct7_b0;
`else
   logic w_unused;
   assign w_r_legal = ~funct7_b0;
   assign w_is_md   = 1'b0;
   assign w_unused  = md_done;
`endif

   assign w_br_taken = funct3[2] ? (BrLT ^ funct3[0]) : (BrEq ^ funct3[0]);

   // Per-opcode datapath controls, derived from the stable instruction register
   always_comb begin
      w_legal     = 1'b1;
      w_is_load   = 1'b0;
      w_is_store  = 1'b0;
      w_is_branch = 1'b0;
      w_imm_sel   = 3'(I_TYPE);
      w_br_un     = 1'b0;
      w_a_sel     = 1'b0;
      w_b_sel     = 1'b0;
      w_wb_sel    = 2'd0;
      w_arith     = 1'b0;
      w_itype     = 1'b0;
      w_pc_sel    = 1'b0;
      case (opcode_eff)
         c_op_r: begin
            w_legal  = w_r_legal;
            w_wb_sel = 2'd1;
            w_arith  = 1'b1;
         end
         c_op_i: begin
            w_b_sel  = 1'b1;
            w_wb_sel = 2'd1;
            w_arith  = 1'b1;
            w_itype  = 1'b1;
         end
         c_op_load: begin
            w_is_load = 1'b1;
            w_b_sel   = 1'b1;
         end
         c_op_store: begin
            w_is_store = 1'b1;
            w_imm_sel  = 3'(S_TYPE);
            w_b_sel    = 1'b1;
         end
         c_op_branch: begin
            w_is_branch = 1'b1;
            w_imm_sel   = 3'(B_TYPE);
            w_br_un     = funct3[1];
            w_a_sel     = 1'b1;
            w_b_sel     = 1'b1;
            w_pc_sel    = w_br_taken;
         end
         c_op_jal: begin
            w_imm_sel = 3'(J_TYPE);
            w_a_sel   = 1'b1;
            w_b_sel   = 1'b1;
            w_wb_sel  = 2'd2;
            w_pc_sel  = 1'b1;
         end
         c_op_jalr: begin
            w_b_sel  = 1'b1;
            w_wb_sel = 2'd2;
            w_pc_sel = 1'b1;
         end
         c_op_auipc: begin
            w_imm_sel = 3'(U_TYPE);
            w_a_sel   = 1'b1;
            w_b_sel   = 1'b1;
            w_wb_sel  = 2'd1;
         end
         c_op_lui: begin
            w_imm_sel = 3'(U_TYPE);
            w_b_sel   = 1'b1;
            w_wb_sel  = 2'd3;
         end
         default: w_legal = 1'b0;
      endcase
   end

   assign w_wd_hit = c_wd_en && (r_wd_cnt == c_wd_limit);

   // Next-state, trap cause and watchdog count; ready beats the timeout limit
   always_comb begin
      w_next_state = r_state;
      w_next_cause = r_trap_cause;
      case (r_state)
         S_FETCH: begin
            if (mem_ready) begin
               w_next_state = S_DECODE;
            end else if (w_wd_hit) begin
               w_next_state = S_TRAP;
               w_next_cause = 2'd2;
            end
         end
         S_DECODE: begin
            if (w_legal) begin
               w_next_state = S_EXECUTE;
            end else begin
               w_next_state = S_TRAP;
               w_next_cause = 2'd1;
            end
         end
         S_EXECUTE: begin
            if (w_is_load || w_is_store) w_next_state = S_MEM;
            else if (w_is_branch)        w_next_state = S_FETCH;
            else if (w_is_md)            w_next_state = S_MULDIV;
            else                         w_next_state = S_WB;
         end
         S_MEM: begin
            if (mem_ready) begin
               w_next_state = w_is_store ? S_FETCH : S_WB;
            end else if (w_wd_hit) begin
               w_next_state = S_TRAP;
               w_next_cause = 2'd2;
            end
         end
         S_WB:     w_next_state = S_FETCH;
         S_MULDIV: if (md_done) w_next_state = S_WB;
         S_TRAP:   w_next_state = S_TRAP;
         default:  w_next_state = S_FETCH;
      endcase
      // Only a stall inside FETCH/MEM keeps the state; every entry restarts at 0
      if ((w_next_state == r_state) && ((r_state == S_FETCH) || (r_state == S_MEM)))
         w_next_cnt = r_wd_cnt + c_wd_w'(1);
      else
         w_next_cnt = '0;
   end

   // Registered FSM; r_run holds everything idle for the cycle after reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_run        <= 1'b0;
         r_state      <= S_FETCH;
         r_wd_cnt     <= '0;
         r_trap_cause <= 2'd0;
      end else begin
         r_run <= 1'b1;
         if (r_run) begin
            r_state      <= w_next_state;
            r_wd_cnt     <= w_next_cnt;
            r_trap_cause <= w_next_cause;
         end
      end
   end

   assign w_in_fetch  = r_run && (r_state == S_FETCH);
   assign w_in_exec   = r_run && (r_state == S_EXECUTE);
   assign w_in_mem    = r_run && (r_state == S_MEM);
   assign w_in_wb     = r_run && (r_state == S_WB);
   assign w_in_muldiv = r_run && (r_state == S_MULDIV);
   assign w_decoded   = r_run && ((r_state == S_DECODE) || w_in_exec || w_in_mem ||
                                  w_in_wb || w_in_muldiv);

   assign mem_req    = w_in_fetch || w_in_mem;
   assign MemRW      = w_in_mem && w_is_store;
   assign ir_we      = w_in_fetch && mem_ready;
   assign pc_we      = (w_in_exec && w_is_branch) || (w_in_mem && w_is_store && mem_ready) || w_in_wb;
   assign RegWEn     = w_in_wb;
   assign PCSel      = w_decoded && w_pc_sel;
   assign ImmSel     = w_decoded ? w_imm_sel : 3'd0;
   assign BrUn       = w_decoded && w_br_un;
   assign ASel       = w_decoded && w_a_sel;
   assign BSel       = w_decoded && w_b_sel;
   assign WBSel      = w_decoded ? w_wb_sel : 2'd0;
   assign arithmetic = w_decoded && w_arith;
   assign i_type     = w_decoded && w_itype;
   assign md_start   = w_in_exec && w_is_md;
   assign md_sel     = (w_in_muldiv || w_in_wb) && w_is_md;
   assign trap       = r_run && (r_state == S_TRAP);
   assign trap_cause = r_trap_cause;
   assign state      = r_state;

endmodule
`default_nettype wire
